uart_line_checker: RTL and testbench

//  Hardware self-check for the serial console. Receives UART frames from serial_rx, collects

---
 rtl/uart_chk_pkg.sv | 15 +
 rtl/uart_rx_core.sv | 124 ++++++++++++
 rtl/uart_line_checker.sv | 144 ++++++++++++++
 tb/tb_uart_line_checker.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_chk_pkg.sv
// Shared types and defaults for the UART console line checker.
package uart_chk_pkg;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_t;

   localparam int         CLK_DIV_DEF   = 16;
   localparam int         DATA_BITS_DEF = 8;
   localparam logic [7:0] TERM_CHAR_DEF = 8'h0A;

endpackage

// File: rtl/uart_rx_core.sv
// UART receiver: 2-flop synchroniser, start/data/stop FSM with a baud divider.
// Emits one-cycle rx_valid_o for good frames and stop_err_o for a low stop bit.
module uart_rx_core
   import uart_chk_pkg::*;
#(
   parameter int CLK_DIV   = CLK_DIV_DEF,
   parameter int DATA_BITS = DATA_BITS_DEF
) (
   input  logic       clk,
   input  logic       rst_ni,
   input  logic       serial_rx_i,
   input  logic       enable_i,
   output logic       rx_valid_o,
   output logic [7:0] rx_data_o,
   output logic       stop_err_o,
   output rx_state_t  state_o
);

   localparam int DIV_W = $clog2(CLK_DIV);
   localparam int BIT_W = $clog2(DATA_BITS + 1);
   localparam logic [DIV_W-1:0] HALF_LAST = DIV_W'(CLK_DIV / 2 - 1);
   localparam logic [DIV_W-1:0] FULL_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);

   logic                 sync1_q, sync2_q, prev_q;
   logic                 fall;
   rx_state_t            state_q, state_d;
   logic [DIV_W-1:0]     div_q, div_d;
   logic [BIT_W-1:0]     bit_q, bit_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 valid_q, valid_d;
   logic [7:0]           data_q, data_d;
   logic                 err_q, err_d;

   // Idle-high line: synchroniser and edge history reset to 1 so reset release is no edge.
   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         prev_q  <= 1'b1;
      end else begin
         sync1_q <= serial_rx_i;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   assign fall = prev_q & ~sync2_q;

   always_comb begin
      state_d = state_q;
      div_d   = div_q + 1'b1;
      bit_d   = bit_q;
      shift_d = shift_q;
      valid_d = 1'b0;
      data_d  = data_q;
      err_d   = 1'b0;
      case (state_q)
         RX_IDLE: begin
            div_d = '0;
            bit_d = '0;
            if (fall) state_d = RX_START;
         end
         RX_START: begin
            if (div_q == HALF_LAST) begin
               div_d   = '0;
               state_d = sync2_q ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            if (div_q == FULL_LAST) begin
               div_d   = '0;
               shift_d = {sync2_q, shift_q[DATA_BITS-1:1]};
               bit_d   = bit_q + 1'b1;
               if (bit_q == LAST_BIT) state_d = RX_STOP;
            end
         end
         RX_STOP: begin
            // Leave at mid-stop so a start bit straight after the stop bit is caught.
            if (div_q == FULL_LAST) begin
               state_d = RX_IDLE;
               if (sync2_q) begin
                  valid_d = 1'b1;
                  data_d  = 8'(shift_q);
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         default: state_d = RX_IDLE;
      endcase
      if (!enable_i) begin
         state_d = RX_IDLE;
         valid_d = 1'b0;
         err_d   = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= RX_IDLE;
         div_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         valid_q <= 1'b0;
         data_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         valid_q <= valid_d;
         data_q  <= data_d;
         err_q   <= err_d;
      end
   end

   assign rx_valid_o = valid_q;
   assign rx_data_o  = data_q;
   assign stop_err_o = err_q;
   assign state_o    = state_q;

endmodule

// File: rtl/uart_line_checker.sv
// UART console self-check: compares every received line against EXP_STR on the fly
// and keeps saturating read/ok/error line counters plus a sticky framing-error flag.
module uart_line_checker
   import uart_chk_pkg::*;
#(
   parameter int                   CLK_DIV   = CLK_DIV_DEF,
   parameter int                   DATA_BITS = DATA_BITS_DEF,
   parameter logic [7:0]           TERM_CHAR = TERM_CHAR_DEF,
   parameter int                   EXP_LEN   = 18,
   parameter int                   MAX_LEN   = 32,
   parameter logic [8*MAX_LEN-1:0] EXP_STR   = {{(8*MAX_LEN-144){1'b0}}, "Hello, world! 123 "},
   parameter int                   CNT_W     = 16
) (
   input  logic             clk,
   input  logic             resetb,
   input  logic             serial_rx,
   input  logic             enable,
   input  logic             clr,
   output logic             rx_valid,
   output logic [7:0]       rx_data,
   output logic             line_done,
   output logic             line_ok,
   output logic [CNT_W-1:0] cnt_rd,
   output logic [CNT_W-1:0] cnt_ok,
   output logic [CNT_W-1:0] cnt_error,
   output logic             frame_err,
   output rx_state_t        rx_state_dbg
);

   localparam int CW = $clog2(MAX_LEN + 1);
   localparam logic [CW-1:0] EXP_LEN_C = CW'(EXP_LEN);
   localparam logic [CW-1:0] MAX_LEN_C = CW'(MAX_LEN);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

   logic [1:0]       rst_sync_q;
   logic             rst_n;
   logic             rx_valid_w, stop_err_w, term;
   logic [7:0]       rx_data_w, exp_char;
   logic             line_match;
   logic [CW-1:0]    idx_q, idx_d;
   logic             bad_q, bad_d;
   logic             ok_q, ok_d;
   logic             ferr_q, ferr_d;
   logic [CNT_W-1:0] rd_q, rd_d, okc_q, okc_d, erc_q, erc_d;

   // Reset asserts asynchronously, releases two clocks later in step with clk.
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) rst_sync_q <= '0;
      else         rst_sync_q <= {rst_sync_q[0], 1'b1};
   end
   assign rst_n = rst_sync_q[1];

   uart_rx_core #(
      .CLK_DIV   (CLK_DIV),
      .DATA_BITS (DATA_BITS)
   ) u_rx (
      .clk         (clk),
      .rst_ni      (rst_n),
      .serial_rx_i (serial_rx),
      .enable_i    (enable),
      .rx_valid_o  (rx_valid_w),
      .rx_data_o   (rx_data_w),
      .stop_err_o  (stop_err_w),
      .state_o     (rx_state_dbg)
   );

   always_comb begin
      exp_char = '0;
      for (int i = 0; i < EXP_LEN; i++) begin
         if (idx_q == CW'(i)) exp_char = EXP_STR[8*(EXP_LEN-1-i) +: 8];
      end
   end

   assign term = rx_valid_w && (rx_data_w == TERM_CHAR);

   always_comb begin
      idx_d      = idx_q;
      bad_d      = bad_q;
      ok_d       = ok_q;
      ferr_d     = ferr_q;
      rd_d       = rd_q;
      okc_d      = okc_q;
      erc_d      = erc_q;
      line_match = !bad_q && (idx_q == EXP_LEN_C);
      if (term) begin
         ok_d = line_match;
         rd_d = sat_inc(rd_q);
         if (line_match) okc_d = sat_inc(okc_q);
         else            erc_d = sat_inc(erc_q);
         idx_d = '0;
         bad_d = 1'b0;
      end else if (rx_valid_w) begin
         if (idx_q >= EXP_LEN_C || rx_data_w != exp_char) bad_d = 1'b1;
         if (idx_q != MAX_LEN_C) idx_d = idx_q + 1'b1;
      end
      if (stop_err_w) begin
         bad_d  = 1'b1;
         ferr_d = 1'b1;
      end
      // Clear wins, including over a line completing in the same cycle.
      if (clr) begin
         idx_d  = '0;
         bad_d  = 1'b0;
         ok_d   = 1'b0;
         ferr_d = 1'b0;
         rd_d   = '0;
         okc_d  = '0;
         erc_d  = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q  <= '0;
         bad_q  <= 1'b0;
         ok_q   <= 1'b0;
         ferr_q <= 1'b0;
         rd_q   <= '0;
         okc_q  <= '0;
         erc_q  <= '0;
      end else begin
         idx_q  <= idx_d;
         bad_q  <= bad_d;
         ok_q   <= ok_d;
         ferr_q <= ferr_d;
         rd_q   <= rd_d;
         okc_q  <= okc_d;
         erc_q  <= erc_d;
      end
   end

   assign rx_valid  = rx_valid_w;
   assign rx_data   = rx_data_w;
   assign line_done = term;
   assign line_ok   = ok_q;
   assign cnt_rd    = rd_q;
   assign cnt_ok    = okc_q;
   assign cnt_error = erc_q;
   assign frame_err = ferr_q;

endmodule

// File: tb/tb_uart_line_checker.sv
// Directed bench for uart_line_checker: drives UART frames, models received lines at
// string level and checks every cycle, plus literal checkpoints after each scenario.
module tb_uart_line_checker;
   import uart_chk_pkg::*;

   localparam int         CLK_DIV = 16;
   localparam int         CNT_W   = 16;
   localparam logic [7:0] TERM    = 8'h0A;

   logic             clk = 1'b0;
   logic             resetb = 1'b0;
   logic             serial_rx = 1'b1;
   logic             enable = 1'b1;
   logic             clr = 1'b0;
   logic             rx_valid;
   logic [7:0]       rx_data;
   logic             line_done;
   logic             line_ok;
   logic [CNT_W-1:0] cnt_rd, cnt_ok, cnt_error;
   logic             frame_err;
   rx_state_t        rx_state_dbg;

   uart_line_checker #(.CLK_DIV(CLK_DIV)) dut (
      .clk          (clk),
      .resetb       (resetb),
      .serial_rx    (serial_rx),
      .enable       (enable),
      .clr          (clr),
      .rx_valid     (rx_valid),
      .rx_data      (rx_data),
      .line_done    (line_done),
      .line_ok      (line_ok),
      .cnt_rd       (cnt_rd),
      .cnt_ok       (cnt_ok),
      .cnt_error    (cnt_error),
      .frame_err    (frame_err),
      .rx_state_dbg (rx_state_dbg)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- scoreboard / model ----------------
   int               checks = 0;
   int               errors = 0;
   int               n_valid = 0;
   bit               chk_en = 1'b0;
   string            exp_s = "Hello, world! 123 ";
   logic [7:0]       exp_q[$];
   logic [7:0]       line_q[$];
   bit               mdl_bad = 1'b0;
   bit               mdl_ferr = 1'b0;
   bit               mdl_ok = 1'b0;
   logic [CNT_W-1:0] mdl_rd = '0, mdl_okc = '0, mdl_erc = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual %0h, required %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [CNT_W-1:0] sat1(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

   function automatic void model_clear();
      mdl_bad  = 1'b0;
      mdl_ferr = 1'b0;
      mdl_ok   = 1'b0;
      mdl_rd   = '0;
      mdl_okc  = '0;
      mdl_erc  = '0;
      line_q.delete();
   endfunction

   function automatic void model_char(input logic [7:0] c);
      bit ok;
      if (c == TERM) begin
         ok = !mdl_bad && (line_q.size() == exp_s.len());
         if (ok) begin
            for (int i = 0; i < line_q.size(); i++) begin
               if (line_q[i] != exp_s[i]) ok = 1'b0;
            end
         end
         mdl_ok = ok;
         mdl_rd = sat1(mdl_rd);
         if (ok) mdl_okc = sat1(mdl_okc);
         else    mdl_erc = sat1(mdl_erc);
         line_q.delete();
         mdl_bad = 1'b0;
      end else begin
         line_q.push_back(c);
      end
   endfunction

   always begin : compare
      logic [7:0] cur;
      bit         got_char;
      @(negedge clk);
      #1;
      if (chk_en) begin
         check("line_ok", line_ok, mdl_ok);
         check("cnt_rd", cnt_rd, mdl_rd);
         check("cnt_ok", cnt_ok, mdl_okc);
         check("cnt_error", cnt_error, mdl_erc);
         got_char = 1'b0;
         cur = '0;
         if (rx_valid) begin
            n_valid++;
            if (exp_q.size() == 0) begin
               check("rx_valid_unexpected", rx_valid, 1'b0);
            end else begin
               cur = exp_q.pop_front();
               got_char = 1'b1;
               check("rx_data", rx_data, cur);
               check("frame_err", frame_err, mdl_ferr);
            end
         end
         check("line_done", line_done, got_char && cur == TERM);
         if (clr) model_clear();
         else if (got_char) model_char(cur);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] ch, input bit stop_ok);
      if (stop_ok) exp_q.push_back(ch);
      serial_rx = 1'b0;
      wait_cycles(CLK_DIV);
      for (int i = 0; i < 8; i++) begin
         serial_rx = ch[i];
         wait_cycles(CLK_DIV);
      end
      serial_rx = stop_ok;
      wait_cycles(CLK_DIV);
      serial_rx = 1'b1;
      if (!stop_ok) begin
         wait_cycles(2 * CLK_DIV);
         mdl_bad  = 1'b1;
         mdl_ferr = 1'b1;
      end
   endtask

   task automatic send_text(input string s, input int gap);
      for (int i = 0; i < s.len(); i++) begin
         send_frame(s[i], 1'b1);
         wait_cycles(gap);
      end
   endtask

   task automatic send_line(input string s, input int gap);
      send_text(s, gap);
      send_frame(TERM, 1'b1);
      wait_cycles(4);
   endtask

   task automatic pulse_clr();
      clr = 1'b1;
      wait_cycles(1);
      clr = 1'b0;
      wait_cycles(2);
   endtask

   task automatic check_counts(input string tag, input int rd, input int okc, input int erc,
                               input bit ok);
      check({tag, "_cnt_rd"}, cnt_rd, rd);
      check({tag, "_cnt_ok"}, cnt_ok, okc);
      check({tag, "_cnt_error"}, cnt_error, erc);
      check({tag, "_line_ok"}, line_ok, ok);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_rx_valid"}, rx_valid, 0);
      check({tag, "_rx_data"}, rx_data, 0);
      check({tag, "_line_done"}, line_done, 0);
      check({tag, "_frame_err"}, frame_err, 0);
      check({tag, "_state"}, rx_state_dbg, RX_IDLE);
      check_counts(tag, 0, 0, 0, 1'b0);
   endtask

   // ---------------- stimulus ----------------
   initial begin : stim
      int waited;
      resetb = 1'b0;
      wait_cycles(3);
      #1;
      check_all_zero("reset");
      @(negedge clk);
      resetb = 1'b1;
      wait_cycles(4);
      chk_en = 1'b1;

      // Correct line with small idle gaps between frames.
      send_line("Hello, world! 123 ", 3);
      check("t1_n_valid", n_valid, 19);
      check_counts("t1", 1, 1, 0, 1'b1);

      pulse_clr();
      check_counts("clr1", 0, 0, 0, 1'b0);

      // Wrong digit, then an empty line; frames back to back from here on.
      send_line("Hello, world! 124 ", 0);
      check_counts("t2", 1, 0, 1, 1'b0);
      send_line("", 0);
      check_counts("t2_empty", 2, 0, 2, 1'b0);

      // One character too many, then one too few.
      send_line("Hello, world! 123 X", 0);
      check_counts("t3_long", 3, 0, 3, 1'b0);
      send_line("Hello, world! 123", 0);
      check_counts("t3_short", 4, 0, 4, 1'b0);

      // Short low glitch: rejected by the start-bit check.
      serial_rx = 1'b0;
      wait_cycles(5);
      serial_rx = 1'b1;
      wait_cycles(3 * CLK_DIV);
      check("t4_glitch_ferr", frame_err, 0);
      check("t4_glitch_state", rx_state_dbg, RX_IDLE);
      check_counts("t4_glitch", 4, 0, 4, 1'b0);

      // Stop bit low on the third character.
      send_text("He", 0);
      send_frame("l", 1'b0);
      send_line("lo, world! 123 ", 0);
      check("t4_frame_err", frame_err, 1);
      check_counts("t4_ferr", 5, 0, 5, 1'b0);

      // Zero-gap good line after the error.
      send_line("Hello, world! 123 ", 0);
      check_counts("t5_b2b", 6, 1, 5, 1'b1);

      // Enable dropped mid-byte: partial byte lost, line state kept.
      send_text("He", 0);
      serial_rx = 1'b0;
      wait_cycles(CLK_DIV);
      serial_rx = 1'b1;
      wait_cycles(CLK_DIV);
      serial_rx = 1'b0;
      wait_cycles(CLK_DIV + CLK_DIV / 2);
      enable = 1'b0;
      serial_rx = 1'b1;
      wait_cycles(2);
      check("t5_en_idle", rx_state_dbg, RX_IDLE);
      wait_cycles(8 * CLK_DIV);
      enable = 1'b1;
      wait_cycles(4);
      send_line("llo, world! 123 ", 0);
      check_counts("t5_enable", 7, 2, 5, 1'b1);

      // clr in the same cycle the terminator completes a good line.
      send_text("Hello, world! 123 ", 0);
      fork
         send_frame(TERM, 1'b1);
         begin
            waited = 0;
            while (!rx_valid && waited < 20 * CLK_DIV) begin
               @(negedge clk);
               waited++;
            end
            check("t6_term_seen", rx_valid, 1);
            clr = 1'b1;
            @(negedge clk);
            clr = 1'b0;
         end
      join
      wait_cycles(4);
      check("t6_frame_err", frame_err, 0);
      check_counts("t6_clr", 0, 0, 0, 1'b0);

      send_line("Hello, world! 123 ", 0);
      check_counts("t7_pre_rst", 1, 1, 0, 1'b1);

      // Reset asserted in the middle of a frame.
      serial_rx = 1'b0;
      wait_cycles(3 * CLK_DIV);
      chk_en = 1'b0;
      resetb = 1'b0;
      #1;
      check_all_zero("t7_rst");
      serial_rx = 1'b1;
      wait_cycles(3);
      resetb = 1'b1;
      exp_q.delete();
      model_clear();
      wait_cycles(4);
      chk_en = 1'b1;
      send_line("Hello, world! 123 ", 0);
      check_counts("t7_post", 1, 1, 0, 1'b1);
      check("t7_exp_q_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
